motion_executor: RTL and testbench

MOTION_EXECUTOR -- requirements
Module: motion_executor

---
 rtl/motion_pkg.sv | 38 +++
 rtl/motion_duration_counter.sv | 40 ++++
 rtl/motion_executor.sv | 161 ++++++++++++++++
 tb/tb_motion_executor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared encodings, defaults and load-count helper for motion_executor
package motion_pkg;

  localparam int CNT_W              = 16;
  localparam int TICKS_PER_UNIT_DEF = 16;
  localparam int TICKS_PER_DEG_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic CMD_STRAIGHT = 1'b0;
  localparam logic CMD_TURN     = 1'b1;
  localparam logic DIR_FWD      = 1'b0;
  localparam logic DIR_REV      = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  // Tick budget for a command: straight uses all 8 angle bits, turns drop the curve flag.
  function automatic logic [CNT_W-1:0] load_count(input logic       cmd_type,
                                                  input logic [7:0] angle,
                                                  input logic [7:0] tpu,
                                                  input logic [7:0] tpd);
    logic [CNT_W-1:0] mag;
    logic [CNT_W-1:0] scale;
    if (cmd_type == CMD_TURN) begin
      mag   = {9'd0, angle[6:0]};
      scale = {8'd0, tpd};
    end else begin
      mag   = {8'd0, angle};
      scale = {8'd0, tpu};
    end
    return mag * scale;
  endfunction

endpackage

// File: rtl/motion_duration_counter.sv
// rtl/motion_duration_counter.sv - tick-duration down counter with load, clear and zero flag
import motion_pkg::*;

module motion_duration_counter (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over load, load wins over decrement; never wrap below zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/motion_executor.sv
// rtl/motion_executor.sv - wheel motion sequencer; MOTION_EXECUTOR_BUMP_STOP_EN adds bump-stop input
import motion_pkg::*;

module motion_executor #(
  parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEF,
  parameter int TICKS_PER_DEG  = TICKS_PER_DEG_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       command_type,
  input  logic       direction,
  input  logic [7:0] angle,
  input  logic       tick,
  input  logic       abort,
`ifdef MOTION_EXECUTOR_BUMP_STOP_EN
  input  logic       bump,
`endif
  output logic       left_en,
  output logic       right_en,
  output logic       left_rev,
  output logic       right_rev,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam logic [7:0] TPU8 = 8'(TICKS_PER_UNIT);
  localparam logic [7:0] TPD8 = 8'(TICKS_PER_DEG);

  state_e           state_q;
  state_e           state_d;
  logic             cmd_type_q;
  logic             dir_q;
  logic             curve_q;
  logic             aborted_q;
  logic             accept;
  logic             abort_go;
  logic             stop_req;
  logic             cnt_load;
  logic             cnt_clr;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] load_val;

  assign load_val = load_count(command_type, angle, TPU8, TPD8);

`ifdef MOTION_EXECUTOR_BUMP_STOP_EN
  assign stop_req = abort |
                    (bump && (cmd_type_q == CMD_STRAIGHT) && (dir_q == DIR_FWD));
`else
  assign stop_req = abort;
`endif

  motion_duration_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state and counter control; stop requests outrank counter expiry.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    abort_go = 1'b0;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_d  = (load_val == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_dec = tick;
        if (stop_req) begin
          abort_go = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the command fields that shape the wheels; the magnitude lives in the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_type_q <= 1'b0;
      dir_q      <= 1'b0;
      curve_q    <= 1'b0;
    end else if (accept) begin
      cmd_type_q <= command_type;
      dir_q      <= direction;
      curve_q    <= angle[7];
    end
  end

  // One-cycle abort pulse, raised in the first IDLE cycle after a stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_go;
    end
  end

  // Wheel drive decoded from the latched command, live only in RUN.
  always_comb begin
    left_en   = 1'b0;
    right_en  = 1'b0;
    left_rev  = 1'b0;
    right_rev = 1'b0;
    if (state_q == ST_RUN) begin
      if (cmd_type_q == CMD_STRAIGHT) begin
        left_en   = 1'b1;
        right_en  = 1'b1;
        left_rev  = dir_q;
        right_rev = dir_q;
      end else if (curve_q) begin
        left_en  = (dir_q == DIR_RIGHT);
        right_en = (dir_q == DIR_LEFT);
      end else begin
        left_en   = 1'b1;
        right_en  = 1'b1;
        left_rev  = (dir_q == DIR_LEFT);
        right_rev = (dir_q == DIR_RIGHT);
      end
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_motion_executor.sv
// tb/tb_motion_executor.sv - scoreboard bench for motion_executor
module tb_motion_executor;

  typedef struct {
    int         ticks;
    logic [3:0] pat;
    bit         ab;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       command_type;
  logic       direction;
  logic [7:0] angle;
  logic       tick;
  logic       abort;
  logic       left_en;
  logic       right_en;
  logic       left_rev;
  logic       right_rev;
  logic       busy;
  logic       done;
  logic       aborted;
`ifdef MOTION_EXECUTOR_BUMP_STOP_EN
  logic       bump = 1'b0;
`endif

  logic [7:0] outs;
  assign outs = {cmd_ready, busy, done, aborted, left_en, right_en, left_rev, right_rev};

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  motion_executor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .command_type (command_type),
    .direction    (direction),
    .angle        (angle),
    .tick         (tick),
    .abort        (abort),
`ifdef MOTION_EXECUTOR_BUMP_STOP_EN
    .bump         (bump),
`endif
    .left_en      (left_en),
    .right_en     (right_en),
    .left_rev     (left_rev),
    .right_rev    (right_rev),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic ctype, input logic dir,
                                  input logic [7:0] ang, input int abort_at);
    exp_t e;
    logic [6:0] a7;
    int n;
    a7 = ang[6:0];
    n = (ctype == 1'b0) ? int'(ang) * 16 : int'(a7) * 4;
    if (ctype == 1'b0)      e.pat = {1'b1, 1'b1, dir, dir};
    else if (ang[7])        e.pat = dir ? 4'b1000 : 4'b0100;
    else                    e.pat = dir ? 4'b1101 : 4'b1110;
    e.ab    = (abort_at > 0);
    e.ticks = e.ab ? abort_at : n;
    if (n == 0 && !e.ab) e.pat = 4'b0000;
    return e;
  endfunction

  // Drive one command, generate ticks every 4th cycle until done/aborted.
  task automatic run_cmd(input logic ctype, input logic dir, input logic [7:0] ang,
                         input int abort_at, input bit hold);
    int  n_ticks;
    bit  fin;
    sb_q.push_back(mk_exp(ctype, dir, ang, abort_at));
    command_type = ctype;
    direction    = dir;
    angle        = ang;
    cmd_valid    = 1'b1;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    n_ticks = 0;
    fin     = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (done || aborted) begin
        fin = 1'b1;
      end else begin
        tick  = (cyc % 4 == 1);
        abort = 1'b0;
        if (tick) begin
          n_ticks++;
          if (n_ticks == abort_at) abort = 1'b1;
        end
        @(posedge clk); #1;
        tick  = 1'b0;
        abort = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    if (!fin) check("timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("ready_after", cmd_ready, 1);
  endtask

  // Monitor: accumulate driven ticks and wheel patterns, settle against the scoreboard.
  initial begin
    int         m_ticks;
    int         m_bad;
    logic [3:0] m_or;
    logic [3:0] pat;
    exp_t       e;
    m_ticks = 0;
    m_bad   = 0;
    m_or    = 4'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        m_ticks = 0;
        m_bad   = 0;
        m_or    = 4'b0;
      end else begin
        pat = {left_en, right_en, left_rev, right_rev};
        if (pat != 4'b0) begin
          if (sb_q.size() == 0) begin
            check("wheels_unexpected", pat, 0);
          end else begin
            if (pat != sb_q[0].pat) m_bad++;
            m_or = m_or | pat;
            if (tick) m_ticks++;
          end
        end
        if (done || aborted) begin
          if (sb_q.size() == 0) begin
            check("spurious_end", {done, aborted}, 0);
          end else begin
            e = sb_q.pop_front();
            check("ticks", m_ticks, e.ticks);
            check("pattern", m_or, e.pat);
            check("pat_stable", m_bad, 0);
            check("end_kind", {done, aborted}, e.ab ? 2'b01 : 2'b10);
            check("end_wheels", pat, 0);
            check("end_busy", busy, !e.ab);
            check("end_ready", cmd_ready, e.ab);
            m_ticks = 0;
            m_bad   = 0;
            m_or    = 4'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    command_type = 1'b0;
    direction    = 1'b0;
    angle        = 8'd0;
    tick         = 1'b0;
    abort        = 1'b0;
    #1;
    check("reset_outs", outs, 8'h80);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outs", outs, 8'h80);

    // abort while idle has no effect
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", {aborted, busy}, 0);

    run_cmd(1'b0, 1'b0, 8'd3,  0, 1'b0);   // straight fwd 48 ticks
    run_cmd(1'b0, 1'b1, 8'd2,  0, 1'b0);   // straight rev 32 ticks
    run_cmd(1'b1, 1'b1, 8'h05, 0, 1'b0);   // spin right 20 ticks
    run_cmd(1'b1, 1'b0, 8'h03, 0, 1'b0);   // spin left 12 ticks
    run_cmd(1'b1, 1'b0, 8'h82, 0, 1'b0);   // curve left 8 ticks
    run_cmd(1'b1, 1'b1, 8'h81, 0, 1'b0);   // curve right 4 ticks
    run_cmd(1'b0, 1'b0, 8'd0,  0, 1'b0);   // zero distance
    run_cmd(1'b1, 1'b1, 8'h80, 0, 1'b0);   // zero-angle curve
    run_cmd(1'b0, 1'b0, 8'd3, 10, 1'b0);   // abort on tick 10
    run_cmd(1'b0, 1'b0, 8'd1,  0, 1'b1);   // cmd_valid held through RUN

    // reset mid-run with the command held
    sb_q.push_back(mk_exp(1'b0, 1'b0, 8'd2, 0));
    command_type = 1'b0;
    direction    = 1'b0;
    angle        = 8'd2;
    cmd_valid    = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      tick = (i % 4 == 1);
      @(posedge clk); #1;
    end
    tick = 1'b0;
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", outs, 8'h80);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_outs", outs, 8'h80);
    rst_n = 1'b1;
    run_cmd(1'b0, 1'b0, 8'd2, 0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
